// File: rtl/dmem_responder.sv
// Data-memory responder: memory-side end of the core's load/store path.
// Accepts one request at a time, waits LATENCY cycles, and then returns
// extended load data or an error flag. Stores are written with byte-lane masking.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready       request handshake
//   req_we/req_addr/req_wdata/req_funct3  request payload (RV32I width/sign code)
//   resp_valid/resp_ready     response handshake
//   resp_rdata/resp_err       response payload (rdata is 0 for stores and errors)
//   busy                      request in flight (hazard-unit stall source)
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned ADDR_W   = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;
  localparam int unsigned CNT_W    = (CNT_INIT > 1) ? $clog2(CNT_INIT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateE;

  stateE              state, stateNext;
  logic [CNT_W-1:0]   waitCnt, waitCntNext;

  logic               weQ;
  logic [31:0]        addrQ;
  logic [31:0]        wdataQ;
  logic [2:0]         funct3Q;

  logic               reqReadyQ, reqReadyNext;
  logic               respValidQ, respValidNext;
  logic [31:0]        respRdataQ, respRdataNext;
  logic               respErrQ, respErrNext;
  logic               busyQ, busyNext;

  logic [31:0]        mem [DEPTH_WORDS];

  logic               accept;
  logic               commit;
  logic               effWe;
  logic [31:0]        effAddr;
  logic [31:0]        effWdata;
  logic [2:0]         effFunct3;
  logic               funct3Bad, misaligned, outOfRange, accessErr;
  logic [ADDR_W-1:0]  wordIdx;
  logic [31:0]        memWord;
  logic [7:0]         laneByte;
  logic [15:0]        laneHalf;
  logic [31:0]        loadData;
  logic [3:0]         wrMask;
  logic [31:0]        wrData;

  assign accept = (state == IDLE) && req_valid;
  // Commit edge is the one entering RESP; with LATENCY=1 that is the accept edge.
  assign commit = (LATENCY == 1) ? accept : ((state == WAIT) && (waitCnt == '0));

  // In IDLE the live request is the one being committed (LATENCY=1); otherwise the latched one.
  always_comb begin
    effWe     = weQ;
    effAddr   = addrQ;
    effWdata  = wdataQ;
    effFunct3 = funct3Q;
    if (state == IDLE) begin
      effWe     = req_we;
      effAddr   = req_addr;
      effWdata  = req_wdata;
      effFunct3 = req_funct3;
    end
  end

  // Fault detection on the committed request.
  always_comb begin
    funct3Bad  = 1'b0;
    if (effWe) begin
      funct3Bad = !(effFunct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      funct3Bad = !(effFunct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
    misaligned = ((effFunct3[1:0] == 2'b01) && effAddr[0]) ||
                 ((effFunct3[1:0] == 2'b10) && (effAddr[1:0] != 2'b00));
    outOfRange = {2'b00, effAddr[31:2]} >= 32'(DEPTH_WORDS);
    accessErr  = funct3Bad || misaligned || outOfRange;
  end

  assign wordIdx  = effAddr[ADDR_W+1:2];
  assign memWord  = mem[wordIdx];
  assign laneByte = memWord[{effAddr[1:0], 3'b000} +: 8];
  assign laneHalf = effAddr[1] ? memWord[31:16] : memWord[15:0];

  // Load alignment and extension.
  always_comb begin
    loadData = '0;
    case (effFunct3)
      3'b000:  loadData = {{24{laneByte[7]}}, laneByte};
      3'b100:  loadData = {24'h000000, laneByte};
      3'b001:  loadData = {{16{laneHalf[15]}}, laneHalf};
      3'b101:  loadData = {16'h0000, laneHalf};
      3'b010:  loadData = memWord;
      default: loadData = '0;
    endcase
  end

  // Store lane replication and byte-enable mask.
  always_comb begin
    wrMask = 4'b0000;
    wrData = effWdata;
    case (effFunct3)
      3'b000: begin
        wrMask = 4'(4'b0001 << effAddr[1:0]);
        wrData = {4{effWdata[7:0]}};
      end
      3'b001: begin
        wrMask = effAddr[1] ? 4'b1100 : 4'b0011;
        wrData = {2{effWdata[15:0]}};
      end
      3'b010: begin
        wrMask = 4'b1111;
        wrData = effWdata;
      end
      default: begin
        wrMask = 4'b0000;
        wrData = effWdata;
      end
    endcase
  end

  // Storage array (not reset); written only on a clean store commit.
  always_ff @(posedge clk) begin
    if (commit && effWe && !accessErr) begin
      for (int i = 0; i < 4; i++) begin
        if (wrMask[i]) begin
          mem[wordIdx][8*i +: 8] <= wrData[8*i +: 8];
        end
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    stateNext     = state;
    waitCntNext   = waitCnt;
    respRdataNext = respRdataQ;
    respErrNext   = respErrQ;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            stateNext = RESP;
          end else begin
            stateNext   = WAIT;
            waitCntNext = CNT_W'(CNT_INIT);
          end
        end
      end
      WAIT: begin
        if (waitCnt == '0) begin
          stateNext = RESP;
        end else begin
          waitCntNext = CNT_W'(waitCnt - 1'b1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (commit) begin
      respErrNext   = accessErr;
      respRdataNext = (effWe || accessErr) ? 32'h0 : loadData;
    end
    reqReadyNext  = (stateNext == IDLE);
    respValidNext = (stateNext == RESP);
    busyNext      = (stateNext != IDLE);
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      waitCnt    <= '0;
      weQ        <= 1'b0;
      addrQ      <= '0;
      wdataQ     <= '0;
      funct3Q    <= '0;
      reqReadyQ  <= 1'b1;
      respValidQ <= 1'b0;
      respRdataQ <= '0;
      respErrQ   <= 1'b0;
      busyQ      <= 1'b0;
    end else begin
      state      <= stateNext;
      waitCnt    <= waitCntNext;
      reqReadyQ  <= reqReadyNext;
      respValidQ <= respValidNext;
      respRdataQ <= respRdataNext;
      respErrQ   <= respErrNext;
      busyQ      <= busyNext;
      if (accept) begin
        weQ     <= req_we;
        addrQ   <= req_addr;
        wdataQ  <= req_wdata;
        funct3Q <= req_funct3;
      end
    end
  end

  assign req_ready  = reqReadyQ;
  assign resp_valid = respValidQ;
  assign resp_rdata = respRdataQ;
  assign resp_err   = respErrQ;
  assign busy       = busyQ;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=2 instance for the main
// scenarios and a small LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned DEPTH1 = 16;
  localparam int unsigned LAT    = 2;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        reqValid, reqReady, reqWe, respValid, respReady, respErr, busy;
  logic [31:0] reqAddr, reqWdata, respRdata;
  logic [2:0]  reqFunct3;

  logic        reqValid1, reqReady1, reqWe1, respValid1, respReady1, respErr1, busy1;
  logic [31:0] reqAddr1, reqWdata1, respRdata1;
  logic [2:0]  reqFunct31;

  int nChecks = 0;
  int nFails  = 0;

  // Byte-addressed reference memories, one per instance.
  logic [7:0] mdl0 [DEPTH*4];
  logic [7:0] mdl1 [DEPTH1*4];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(reqValid), .req_ready(reqReady), .req_we(reqWe),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_funct3(reqFunct3),
    .resp_valid(respValid), .resp_ready(respReady),
    .resp_rdata(respRdata), .resp_err(respErr), .busy(busy)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH1), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(reqValid1), .req_ready(reqReady1), .req_we(reqWe1),
    .req_addr(reqAddr1), .req_wdata(reqWdata1), .req_funct3(reqFunct31),
    .resp_valid(respValid1), .resp_ready(respReady1),
    .resp_rdata(respRdata1), .resp_err(respErr1), .busy(busy1)
  );

  // Reference: access legality, little-endian byte gather/scatter, extension.
  function automatic void mdlAccess(input int sel, input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [2:0] f3,
                                    output logic err, output logic [31:0] rd);
    int unsigned size;
    int unsigned depth;
    logic [31:0] val;
    logic [31:0] mask;
    depth = (sel == 0) ? DEPTH : DEPTH1;
    size  = 32'd1 << f3[1:0];
    err   = we ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if ((addr % size) != 0) err = 1'b1;
    if ((addr >> 2) >= depth) err = 1'b1;
    rd = 32'h0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < int'(size); i++) begin
        if (sel == 0) mdl0[addr + 32'(i)] = 8'(wdata >> (8 * i));
        else          mdl1[addr + 32'(i)] = 8'(wdata >> (8 * i));
      end
    end else begin
      val = 32'h0;
      for (int i = 0; i < int'(size); i++) begin
        if (sel == 0) val = val | (32'(mdl0[addr + 32'(i)]) << (8 * i));
        else          val = val | (32'(mdl1[addr + 32'(i)]) << (8 * i));
      end
      if (size < 4) begin
        mask = (32'd1 << (8 * size)) - 32'd1;
        if (!f3[2] && val[8*size-1]) val = val | ~mask;
      end
      rd = val;
    end
  endfunction

  // One complete transaction on the LATENCY=2 instance; lat counts cycles to resp_valid.
  task automatic doReq(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, output logic [31:0] rd, output logic err,
                       output int lat);
    int n;
    @(negedge clk);
    reqValid = 1'b1; reqWe = we; reqAddr = addr; reqWdata = wdata; reqFunct3 = f3;
    n = 0;
    while (!reqReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    lat = 1;
    while (!respValid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd  = respRdata;
    err = respErr;
    respReady = 1'b1;
    @(negedge clk);
    respReady = 1'b0;
  endtask

  task automatic runOp(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, output logic [31:0] rd, output logic err,
                       output int lat, output logic [31:0] expRd, output logic expErr);
    doReq(we, addr, wdata, f3, rd, err, lat);
    mdlAccess(0, we, addr, wdata, f3, expErr, expRd);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    nChecks++;
    if ({reqReady, respValid, respErr, busy} !== 4'b1000) begin
      nFails++;
      $display("FAIL reset_ctrl: got ready/valid/err/busy=%b expected 1000",
               {reqReady, respValid, respErr, busy});
    end
    nChecks++;
    if (respRdata !== 32'h0) begin
      nFails++;
      $display("FAIL reset_rdata: got %h expected 00000000", respRdata);
    end
    reset = 1'b1;
    @(negedge clk);
    nChecks++;
    if ({reqReady, busy} !== 2'b10) begin
      nFails++;
      $display("FAIL reset_release: got ready/busy=%b expected 10", {reqReady, busy});
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd, expRd;
    logic err, expErr;
    int lat;
    runOp(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, err, lat, expRd, expErr);
    nChecks++;
    if (lat !== int'(LAT)) begin
      nFails++;
      $display("FAIL sw_latency: got %0d expected %0d", lat, LAT);
    end
    nChecks++;
    if ({err, rd} !== {1'b0, 32'h0}) begin
      nFails++;
      $display("FAIL sw_resp: got err=%b rdata=%h expected err=0 rdata=0", err, rd);
    end
    runOp(1'b0, 32'h10, 32'h0, 3'b010, rd, err, lat, expRd, expErr);
    nChecks++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
      nFails++;
      $display("FAIL lw_after_sw: got %h err=%b expected deadbeef err=0", rd, err);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd, expRd;
    logic err, expErr;
    int lat;
    runOp(1'b1, 32'h10, 32'h11223344, 3'b010, rd, err, lat, expRd, expErr);
    runOp(1'b1, 32'h11, 32'h000000A5, 3'b000, rd, err, lat, expRd, expErr);
    runOp(1'b0, 32'h10, 32'h0, 3'b010, rd, err, lat, expRd, expErr);
    nChecks++;
    if (rd !== 32'h1122A544 || rd !== expRd) begin
      nFails++;
      $display("FAIL sb_merge: got %h expected 1122a544", rd);
    end
    runOp(1'b0, 32'h11, 32'h0, 3'b000, rd, err, lat, expRd, expErr);
    nChecks++;
    if (rd !== 32'hFFFFFFA5) begin
      nFails++;
      $display("FAIL lb_sign: got %h expected ffffffa5", rd);
    end
    runOp(1'b0, 32'h11, 32'h0, 3'b100, rd, err, lat, expRd, expErr);
    nChecks++;
    if (rd !== 32'h000000A5) begin
      nFails++;
      $display("FAIL lbu_zero: got %h expected 000000a5", rd);
    end
    runOp(1'b0, 32'h12, 32'h0, 3'b001, rd, err, lat, expRd, expErr);
    nChecks++;
    if (rd !== 32'h00001122) begin
      nFails++;
      $display("FAIL lh_upper: got %h expected 00001122", rd);
    end
  endtask

  task automatic test_faults();
    logic [31:0] rd, expRd;
    logic err, expErr;
    int lat;
    runOp(1'b0, 32'h13, 32'h0, 3'b001, rd, err, lat, expRd, expErr);
    nChecks++;
    if ({err, rd} !== {1'b1, 32'h0}) begin
      nFails++;
      $display("FAIL lh_misaligned: got err=%b rdata=%h expected err=1 rdata=0", err, rd);
    end
    runOp(1'b1, 32'h12, 32'hFFFFFFFF, 3'b010, rd, err, lat, expRd, expErr);
    nChecks++;
    if (err !== 1'b1) begin
      nFails++;
      $display("FAIL sw_misaligned: got err=%b expected 1", err);
    end
    runOp(1'b0, 32'h10, 32'h0, 3'b010, rd, err, lat, expRd, expErr);
    nChecks++;
    if (rd !== 32'h1122A544) begin
      nFails++;
      $display("FAIL fault_no_write: got %h expected 1122a544", rd);
    end
    runOp(1'b0, 32'(4 * DEPTH), 32'h0, 3'b010, rd, err, lat, expRd, expErr);
    nChecks++;
    if ({err, rd} !== {1'b1, 32'h0}) begin
      nFails++;
      $display("FAIL out_of_range: got err=%b rdata=%h expected err=1 rdata=0", err, rd);
    end
    runOp(1'b0, 32'h10, 32'h0, 3'b011, rd, err, lat, expRd, expErr);
    nChecks++;
    if (err !== 1'b1) begin
      nFails++;
      $display("FAIL load_f3_011: got err=%b expected 1", err);
    end
    runOp(1'b1, 32'h10, 32'h0, 3'b100, rd, err, lat, expRd, expErr);
    nChecks++;
    if (err !== 1'b1) begin
      nFails++;
      $display("FAIL store_f3_100: got err=%b expected 1", err);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, expRd;
    logic err, expErr;
    int n;
    mdlAccess(0, 1'b0, 32'h10, 32'h0, 3'b010, expErr, expRd);
    @(negedge clk);
    reqValid = 1'b1; reqWe = 1'b0; reqAddr = 32'h10; reqWdata = 32'h0; reqFunct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    n = 0;
    while (!respValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    // A store that would clobber the word if it were wrongly accepted.
    for (int i = 0; i < 5; i++) begin
      reqValid = 1'b1; reqWe = 1'b1; reqAddr = 32'h10; reqWdata = 32'h0; reqFunct3 = 3'b010;
      nChecks++;
      if ({respValid, respErr, reqReady, busy} !== 4'b1001 || respRdata !== expRd) begin
        nFails++;
        $display("FAIL hold_cycle%0d: got valid/err/ready/busy=%b rdata=%h expected 1001 rdata=%h",
                 i, {respValid, respErr, reqReady, busy}, respRdata, expRd);
      end
      @(negedge clk);
    end
    reqValid  = 1'b0;
    respReady = 1'b1;
    @(negedge clk);
    respReady = 1'b0;
    nChecks++;
    if ({respValid, reqReady, busy} !== 3'b010) begin
      nFails++;
      $display("FAIL release_idle: got valid/ready/busy=%b expected 010", {respValid, reqReady, busy});
    end
    runOp(1'b0, 32'h10, 32'h0, 3'b010, rd, err, n, expRd, expErr);
    nChecks++;
    if (rd !== expRd) begin
      nFails++;
      $display("FAIL ignored_req_no_write: got %h expected %h", rd, expRd);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd, expRd;
    logic err, expErr;
    int lat;
    runOp(1'b1, 32'h20, 32'hCAFEF00D, 3'b010, rd, err, lat, expRd, expErr);
    runOp(1'b0, 32'h20, 32'h0, 3'b010, rd, err, lat, expRd, expErr);
    @(negedge clk);
    reqValid = 1'b1; reqWe = 1'b1; reqAddr = 32'h20; reqWdata = 32'h12345678; reqFunct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    nChecks++;
    if ({busy, respValid} !== 2'b10) begin
      nFails++;
      $display("FAIL wait_state: got busy/valid=%b expected 10", {busy, respValid});
    end
    reset = 1'b0;
    #1;
    nChecks++;
    if ({reqReady, respValid, respErr, busy} !== 4'b1000 || respRdata !== 32'h0) begin
      nFails++;
      $display("FAIL reset_in_wait: got ready/valid/err/busy=%b rdata=%h expected 1000 rdata=0",
               {reqReady, respValid, respErr, busy}, respRdata);
    end
    @(negedge clk);
    reset = 1'b1;
    runOp(1'b0, 32'h20, 32'h0, 3'b010, rd, err, lat, expRd, expErr);
    nChecks++;
    if (rd !== 32'hCAFEF00D || rd !== expRd) begin
      nFails++;
      $display("FAIL dropped_store: got %h expected cafef00d", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, expRd, addr, wdata;
    logic err, expErr, we;
    logic [2:0] f3;
    int lat, r;
    for (int w = 0; w < 16; w++) begin
      runOp(1'b1, 32'(4 * w), $urandom, 3'b010, rd, err, lat, expRd, expErr);
    end
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      case (r)
        0, 1:    f3 = 3'b000;
        2, 3:    f3 = 3'b001;
        4, 5:    f3 = 3'b010;
        6:       f3 = 3'b100;
        7:       f3 = 3'b101;
        8:       f3 = 3'b011;
        default: f3 = 3'(6 + $urandom_range(0, 1));
      endcase
      addr  = ($urandom_range(0, 15) == 0) ? 32'(4 * DEPTH) + $urandom_range(0, 7)
                                           : $urandom_range(0, 63);
      wdata = $urandom;
      runOp(we, addr, wdata, f3, rd, err, lat, expRd, expErr);
      nChecks++;
      if (rd !== expRd || err !== expErr || lat !== int'(LAT)) begin
        nFails++;
        $display("FAIL rand%0d we=%b f3=%b addr=%h: got rdata=%h err=%b lat=%0d expected rdata=%h err=%b lat=%0d",
                 i, we, f3, addr, rd, err, lat, expRd, expErr, LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        opWe [8]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] opAddr [8] = '{32'h0, 32'h4, 32'h6, 32'h4, 32'h7, 32'h2, 32'h1, 32'h0};
    logic [31:0] opData [8] = '{32'hA1B2C3D4, 32'h01020304, 32'h0000BEEF, 32'h0,
                                32'h0, 32'h0, 32'h00000077, 32'h0};
    logic [2:0]  opF3 [8]   = '{3'b010, 3'b010, 3'b001, 3'b010, 3'b000, 3'b101, 3'b000, 3'b010};
    logic [32:0] expQ [$];
    logic [32:0] exp;
    logic [31:0] expRd;
    logic        expErr;
    int cyc, k, nResp, lastAcc;
    cyc = 0; k = 0; nResp = 0; lastAcc = -10;
    respReady1 = 1'b1;
    @(negedge clk);
    while (nResp < 8 && cyc < 60) begin
      if (respValid1) begin
        exp = expQ.pop_front();
        nChecks++;
        if (cyc != lastAcc + 1 || {respErr1, respRdata1} !== exp) begin
          nFails++;
          $display("FAIL b2b_resp%0d: got err/rdata=%h after %0d cycles expected %h after 1",
                   nResp, {respErr1, respRdata1}, cyc - lastAcc, exp);
        end
        nResp++;
      end
      if (reqReady1 && k < 8) begin
        reqValid1 = 1'b1; reqWe1 = opWe[k]; reqAddr1 = opAddr[k];
        reqWdata1 = opData[k]; reqFunct31 = opF3[k];
        mdlAccess(1, opWe[k], opAddr[k], opData[k], opF3[k], expErr, expRd);
        expQ.push_back({expErr, expRd});
        if (k > 0) begin
          nChecks++;
          if (cyc - lastAcc != 2) begin
            nFails++;
            $display("FAIL b2b_spacing%0d: got %0d cycles expected 2", k, cyc - lastAcc);
          end
        end
        lastAcc = cyc;
        k++;
      end else if (reqReady1) begin
        reqValid1 = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    reqValid1  = 1'b0;
    respReady1 = 1'b0;
    nChecks++;
    if (nResp != 8) begin
      nFails++;
      $display("FAIL b2b_count: got %0d responses expected 8", nResp);
    end
  endtask

  initial begin
    reset = 1'b0;
    reqValid = 1'b0; reqWe = 1'b0; reqAddr = '0; reqWdata = '0; reqFunct3 = '0; respReady = 1'b0;
    reqValid1 = 1'b0; reqWe1 = 1'b0; reqAddr1 = '0; reqWdata1 = '0; reqFunct31 = '0; respReady1 = 1'b0;
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_faults();
    test_backpressure();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
